// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, scheduler state encoding and default width.
package alu_pkg;

    localparam int unsigned LEN_DEF = 8;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_SHL  = 4'b0111;
    localparam logic [3:0] OP_SHR  = 4'b1000;
    localparam logic [3:0] OP_LAST = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_defined(input logic [3:0] code);
        return code <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Requester and response channels between the issue logic and alu_sched.
interface alu_sched_if
    import alu_pkg::*;
#(
    parameter int LEN = LEN_DEF
);
    logic           req0_valid;
    logic           req0_ready;
    logic [LEN-1:0] req0_a;
    logic [LEN-1:0] req0_b;
    logic [3:0]     req0_code;

    logic           req1_valid;
    logic           req1_ready;
    logic [LEN-1:0] req1_a;
    logic [LEN-1:0] req1_b;
    logic [3:0]     req1_code;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [LEN-1:0] rsp_data;
    logic           rsp_id;
    logic           rsp_zero;
    logic           rsp_err;
    logic           busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_code,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_code,
        input  req1_ready,
        input  rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_err, busy,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_code,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_code,
        output req1_ready,
        output rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_err, busy,
        input  rsp_ready
    );
endinterface

// File: rtl/alu.sv
// Combinational ALU; modulo-2^LEN arithmetic, zero-fill shifts, unsigned truncating divide.
module alu
    import alu_pkg::*;
#(
    parameter int LEN = LEN_DEF
) (
    input  logic [LEN-1:0] a,
    input  logic [LEN-1:0] b,
    input  logic [3:0]     code,
    output logic [LEN-1:0] y
);

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        y = '0;
        case (code)
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_MUL: y = a * b;
            OP_DIV: y = (b == '0) ? '0 : a / b;
            OP_XOR: y = a ^ b;
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_SHL: y = {a[LEN-2:0], 1'b0};
            OP_SHR: y = {1'b0, a[LEN-1:1]};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_sched.sv
// Round-robin two-requester front end for one shared alu: capture, execute one cycle,
// then hold a registered result with zero/error flags until the consumer takes it.
module alu_sched
    import alu_pkg::*;
#(
    parameter int LEN = LEN_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_sched_if.slave  bus
);

    state_t         state;
    logic           rr;
    logic           id;
    logic [LEN-1:0] op_a;
    logic [LEN-1:0] op_b;
    logic [3:0]     op_code;

    logic           rsp_valid;
    logic [LEN-1:0] rsp_data;
    logic           rsp_id;
    logic           rsp_zero;
    logic           rsp_err;
    logic           busy;

    logic           grant_any;
    logic           grant_id;
    logic           accept;
    logic [LEN-1:0] alu_y;
    logic           div_zero;
    logic           undef;
    logic [LEN-1:0] res_data;
    logic           res_err;

    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        grant_id  = (bus.req0_valid && bus.req1_valid) ? rr : bus.req1_valid;
    end

    // Gated by rst_n so nothing is offered a grant while held in reset.
    assign accept         = rst_n && (state == IDLE) && grant_any;
    assign bus.req0_ready = accept && !grant_id;
    assign bus.req1_ready = accept && grant_id;

    alu #(.LEN(LEN)) u_alu (
        .a    (op_a),
        .b    (op_b),
        .code (op_code),
        .y    (alu_y)
    );

    always_comb begin
        div_zero = (op_code == OP_DIV) && (op_b == '0);
        undef    = !op_defined(op_code);
        res_err  = div_zero | undef;
        if (undef)         res_data = '0;
        else if (div_zero) res_data = '1;
        else               res_data = alu_y;
    end

    // NOTE: operand registers are reset along with control so the ALU never sees X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= 1'b0;
            id        <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_code   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a    <= grant_id ? bus.req1_a    : bus.req0_a;
                        op_b    <= grant_id ? bus.req1_b    : bus.req0_b;
                        op_code <= grant_id ? bus.req1_code : bus.req0_code;
                        id      <= grant_id;
                        rr      <= ~grant_id;
                        busy    <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= res_data;
                    rsp_err   <= res_err;
                    rsp_zero  <= (res_data == '0);
                    rsp_id    <= id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_zero  = rsp_zero;
    assign bus.rsp_err   = rsp_err;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_alu_sched.sv
// Directed-vector bench for alu_sched: arbitration, opcodes, error flags, backpressure, reset.
module tb_alu_sched;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;

    alu_sched_if #(.LEN(8)) bus ();

    alu_sched #(.LEN(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rid, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] code, input bit valid);
        if (rid) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_code = code; bus.req1_valid = valid;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_code = code; bus.req0_valid = valid;
        end
    endtask

    // One operation from a single requester with rsp_ready high; checks latency and result.
    task automatic run_op(input string tag, input bit rid, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] code,
                          input logic [7:0] exp_data, input bit exp_zero, input bit exp_err);
        int n;
        @(negedge clk);
        drive(rid, a, b, code, 1'b1);
        #1;
        n = 0;
        while (!(rid ? bus.req1_ready : bus.req0_ready) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready"}, {31'd0, rid ? bus.req1_ready : bus.req0_ready}, 32'd1);
        @(posedge clk);
        #1;
        drive(rid, 8'h00, 8'h00, 4'h0, 1'b0);
        @(negedge clk);
        check({tag, " exec valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        check({tag, " valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check({tag, " data"},  {24'd0, bus.rsp_data}, {24'd0, exp_data});
        check({tag, " id"},    {31'd0, bus.rsp_id},   {31'd0, rid});
        check({tag, " zero"},  {31'd0, bus.rsp_zero}, {31'd0, exp_zero});
        check({tag, " err"},   {31'd0, bus.rsp_err},  {31'd0, exp_err});
        @(negedge clk);
        check({tag, " valid drop"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        int g;
        int ph;
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        bus.rsp_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
        drive(1'b1, 8'h00, 8'h00, 4'h0, 1'b0);

        // Reset state, with both requesters already valid.
        repeat (2) @(negedge clk);
        drive(1'b0, 8'd1, 8'd1, OP_ADD, 1'b1);
        drive(1'b1, 8'd3, 8'd2, OP_MUL, 1'b1);
        @(negedge clk);
        check("rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst rsp_data",  {24'd0, bus.rsp_data},  32'd0);
        check("rst rsp_id",    {31'd0, bus.rsp_id},    32'd0);
        check("rst rsp_zero",  {31'd0, bus.rsp_zero},  32'd0);
        check("rst rsp_err",   {31'd0, bus.rsp_err},   32'd0);
        check("rst busy",      {31'd0, bus.busy},      32'd0);
        check("rst ready0",    {31'd0, bus.req0_ready}, 32'd0);
        check("rst ready1",    {31'd0, bus.req1_ready}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Both held valid: grants alternate req0, req1, req0.
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            g  = (k / 3) % 2;
            ph = k % 3;
            check("rr one ready", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
            if (ph == 0) begin
                check("rr ready0", {31'd0, bus.req0_ready}, (g == 0) ? 32'd1 : 32'd0);
                check("rr ready1", {31'd0, bus.req1_ready}, (g == 1) ? 32'd1 : 32'd0);
            end else if (ph == 1) begin
                check("rr exec valid", {31'd0, bus.rsp_valid}, 32'd0);
                check("rr exec busy",  {31'd0, bus.busy},      32'd1);
            end else begin
                check("rr valid", {31'd0, bus.rsp_valid}, 32'd1);
                check("rr data",  {24'd0, bus.rsp_data},  (g == 1) ? 32'd6 : 32'd2);
                check("rr id",    {31'd0, bus.rsp_id},    g[31:0]);
            end
        end
        // Valid dropped before the edge: nothing is latched.
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
        drive(1'b1, 8'h00, 8'h00, 4'h0, 1'b0);
        @(negedge clk);
        check("drop busy", {31'd0, bus.busy}, 32'd0);

        run_op("add",   1'b0, 8'd200, 8'd100, OP_ADD, 8'd44,  1'b0, 1'b0);
        run_op("sub0",  1'b1, 8'd5,   8'd5,   OP_SUB, 8'd0,   1'b1, 1'b0);
        run_op("div0",  1'b1, 8'd7,   8'd0,   OP_DIV, 8'hFF,  1'b0, 1'b1);
        run_op("undef", 1'b0, 8'd9,   8'd4,   4'b1010, 8'd0,  1'b1, 1'b1);
        run_op("shl",   1'b0, 8'h81,  8'h00,  OP_SHL, 8'h02,  1'b0, 1'b0);
        run_op("shr",   1'b1, 8'h81,  8'h00,  OP_SHR, 8'h40,  1'b0, 1'b0);
        run_op("mul",   1'b0, 8'd20,  8'd13,  OP_MUL, 8'd4,   1'b0, 1'b0);
        run_op("div",   1'b1, 8'd100, 8'd7,   OP_DIV, 8'd14,  1'b0, 1'b0);
        run_op("xor",   1'b0, 8'hF0,  8'h3C,  OP_XOR, 8'hCC,  1'b0, 1'b0);
        run_op("and",   1'b1, 8'hF0,  8'h3C,  OP_AND, 8'h30,  1'b0, 1'b0);
        run_op("or",    1'b0, 8'hF0,  8'h3C,  OP_OR,  8'hFC,  1'b0, 1'b0);
        run_op("subw",  1'b0, 8'd3,   8'd5,   OP_SUB, 8'hFE,  1'b0, 1'b0);

        // Backpressure: result held for 5 cycles with req0 still valid.
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        drive(1'b0, 8'd9, 8'd3, OP_DIV, 1'b1);
        #1 check("hold ready", {31'd0, bus.req0_ready}, 32'd1);
        @(posedge clk);
        #1 drive(1'b0, 8'd1, 8'd1, OP_ADD, 1'b1);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold valid",  {31'd0, bus.rsp_valid},  32'd1);
            check("hold data",   {24'd0, bus.rsp_data},   32'd3);
            check("hold flags",  {30'd0, bus.rsp_zero, bus.rsp_err}, 32'd0);
            check("hold id",     {31'd0, bus.rsp_id},     32'd0);
            check("hold ready0", {31'd0, bus.req0_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("release valid",  {31'd0, bus.rsp_valid},  32'd0);
        check("release ready0", {31'd0, bus.req0_ready}, 32'd1);
        @(posedge clk);
        #1 drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("next data", {24'd0, bus.rsp_data}, 32'd2);
        @(negedge clk);

        // Reset during EXEC discards the operation and restores req0 priority.
        @(negedge clk);
        drive(1'b0, 8'd50, 8'd50, OP_ADD, 1'b1);
        @(posedge clk);
        #1 drive(1'b0, 8'd10, 8'd20, OP_ADD, 1'b1);
        drive(1'b1, 8'd0, 8'd0, OP_AND, 1'b1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midrst busy",   {31'd0, bus.busy},      32'd0);
        check("midrst valid",  {31'd0, bus.rsp_valid}, 32'd0);
        check("midrst readys", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("postrst ready0", {31'd0, bus.req0_ready}, 32'd1);
        check("postrst ready1", {31'd0, bus.req1_ready}, 32'd0);
        check("postrst valid",  {31'd0, bus.rsp_valid},  32'd0);
        @(posedge clk);
        #1 drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
        drive(1'b1, 8'h00, 8'h00, 4'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("postrst data", {24'd0, bus.rsp_data}, 32'd30);
        check("postrst id",   {31'd0, bus.rsp_id},   32'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
